// File: rtl/player_tracker_gen.sv
// player_tracker_gen: mouse-driven player square with clamped motion, pixel strobe and vblank BRAM collision/shading probe
module player_tracker_gen #(
  parameter int HBP        = 296,
  parameter int VBP        = 35,
  parameter int FIELD_W    = 704,
  parameter int FIELD_H    = 760,
  parameter int SIZE       = 10,
  parameter int VEL        = 3,
  parameter int XSTART     = 600,
  parameter int YSTART     = 400,
  parameter int DEADZONE   = 200,
  parameter int PROBE      = 8,
  parameter int ROW_W      = 1024,
  parameter int AW         = 10,
  parameter int RD_LAT     = 2,
  parameter int FETCH_LINE = 805
) (
  input  logic             clk_65M,
  input  logic             clear,
  input  logic             game_start,
  input  logic [16:0]      h_count,
  input  logic [16:0]      v_count,
  input  logic             mouse_valid,
  input  logic [7:0]       byte3,
  input  logic [8:0]       x_data,
  input  logic [8:0]       y_data,
  input  logic [ROW_W-1:0] r_data_lsb,
  input  logic [ROW_W-1:0] r_data_msb,
  output logic [AW-1:0]    r_addr,
  output logic             rd_en,
  output logic             player_on,
  output logic             in_shaded,
  output logic             game_over,
  output logic [16:0]      player_x,
  output logic [16:0]      player_y,
  output logic             fetch_busy
);
  localparam int CW = $clog2(ROW_W);
  localparam int LW = $clog2(RD_LAT + 1);
  localparam logic signed [17:0] V    = 18'(VEL);
  localparam logic signed [17:0] XMAX = 18'(FIELD_W - SIZE);
  localparam logic signed [17:0] YMAX = 18'(FIELD_H - SIZE);
  typedef enum logic [2:0] {IDLE, ADDR_UP, WAIT_UP, CAP_UP, ADDR_DN, WAIT_DN, CAP_DN, EVAL} state_t;
  state_t state, nstate;
  logic rst, tick, start;
  logic left, right, up, down;
  logic signed [17:0] nx, ny, cx, cy;
  logic [17:0] hx, vy, dn_sum;
  logic [AW-1:0] up_addr, dn_addr;
  logic [LW-1:0] cnt;
  logic [16:0] sx, sy;
  logic [ROW_W-1:0] up_l, up_m, dn_l, dn_m;
  logic [CW-1:0] cl, cr, c0, c1;
  logic shaded, hazard;
  logic unused_bits;
  assign rst        = clear | game_start;
  assign tick       = h_count == '0 && v_count == '0;
  assign start      = v_count == 17'(FETCH_LINE) && h_count == 17'd1;
  assign fetch_busy = state != IDLE;
  assign hx         = {1'b0, player_x} + 18'(HBP);
  assign vy         = {1'b0, player_y} + 18'(VBP);
  assign player_on  = {1'b0, h_count} >= hx && {1'b0, h_count} < hx + 18'(SIZE) &&
                      {1'b0, v_count} >= vy && {1'b0, v_count} < vy + 18'(SIZE);
  assign unused_bits = ^{byte3[7:4], byte3[1:0], cx[17], cy[17]};
  function automatic logic [CW-1:0] sat(input logic [17:0] v);
    return v > 18'(ROW_W - 1) ? CW'(ROW_W - 1) : v[CW-1:0];
  endfunction
  function automatic logic is_trail(input logic [ROW_W-1:0] m, input logic [ROW_W-1:0] l, input logic [CW-1:0] c);
    return m[c] & ~l[c];
  endfunction
  function automatic logic is_shade(input logic [ROW_W-1:0] m, input logic [ROW_W-1:0] l, input logic [CW-1:0] c);
    return m[c] & l[c];
  endfunction
  // Latch the mouse direction; a magnitude inside the dead zone means no motion on that axis
  always_ff @(posedge clk_65M)
    if (rst) {left, right, up, down} <= '0;
    else if (mouse_valid) begin
      left  <= byte3[3] & (x_data > 9'(DEADZONE));
      right <= ~byte3[3] & (x_data > 9'(DEADZONE));
      up    <= byte3[2] & (y_data > 9'(DEADZONE));
      down  <= ~byte3[2] & (y_data > 9'(DEADZONE));
    end
  // Candidate next position in signed arithmetic, clamped to the play field
  always_comb begin
    nx = $signed({1'b0, player_x}) + (right ? V : 18'sd0) - (left ? V : 18'sd0);
    ny = $signed({1'b0, player_y}) + (down ? V : 18'sd0) - (up ? V : 18'sd0);
    cx = nx < 18'sd0 ? 18'sd0 : nx > XMAX ? XMAX : nx;
    cy = ny < 18'sd0 ? 18'sd0 : ny > YMAX ? YMAX : ny;
  end
  // Position advances once per frame and freezes after a collision
  always_ff @(posedge clk_65M)
    if (rst) begin
      player_x <= 17'(XSTART);
      player_y <= 17'(YSTART);
    end else if (tick && !game_over) begin
      player_x <= cx[16:0];
      player_y <= cy[16:0];
    end
  // Row addresses: above the square from the live position, below it from the snapshot
  always_comb begin
    up_addr = player_y < 17'd2 ? '0 : AW'(player_y - 17'd2);
    dn_sum  = {1'b0, sy} + 18'(SIZE + 2);
    dn_addr = dn_sum > 18'((1 << AW) - 1) ? '1 : dn_sum[AW-1:0];
  end
  // Fetch sequencing: address, wait out the read latency, capture, then evaluate
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    nstate = start ? ADDR_UP : IDLE;
      ADDR_UP: nstate = WAIT_UP;
      WAIT_UP: nstate = cnt == LW'(RD_LAT - 1) ? CAP_UP : WAIT_UP;
      CAP_UP:  nstate = ADDR_DN;
      ADDR_DN: nstate = WAIT_DN;
      WAIT_DN: nstate = cnt == LW'(RD_LAT - 1) ? CAP_DN : WAIT_DN;
      CAP_DN:  nstate = EVAL;
      EVAL:    nstate = IDLE;
    endcase
  end
  // FSM state, latency counter and registered BRAM address/enable
  always_ff @(posedge clk_65M)
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rd_en  <= 1'b0;
      r_addr <= '0;
    end else begin
      state  <= nstate;
      cnt    <= (state == WAIT_UP || state == WAIT_DN) && nstate == state ? cnt + 1'b1 : '0;
      rd_en  <= nstate == ADDR_UP || nstate == ADDR_DN;
      r_addr <= nstate == ADDR_UP ? up_addr : nstate == ADDR_DN ? dn_addr : r_addr;
    end
  // Snapshot position at fetch start and capture both rows; contents are always refreshed before use
  always_ff @(posedge clk_65M) begin
    if (state == IDLE && start) {sx, sy} <= {player_x, player_y};
    if (state == CAP_UP) {up_m, up_l} <= {r_data_msb, r_data_lsb};
    if (state == CAP_DN) {dn_m, dn_l} <= {r_data_msb, r_data_lsb};
  end
  // Probe and corner columns, saturated into the row
  always_comb begin
    cl = {1'b0, sx} < 18'(PROBE) ? '0 : sat({1'b0, sx} - 18'(PROBE));
    cr = sat({1'b0, sx} + 18'(SIZE + PROBE));
    c0 = sat({1'b0, sx});
    c1 = sat({1'b0, sx} + 18'(SIZE));
    shaded = is_shade(up_m, up_l, c0) & is_shade(up_m, up_l, c1) &
             is_shade(dn_m, dn_l, c0) & is_shade(dn_m, dn_l, c1);
    hazard = (up    & is_trail(up_m, up_l, cl) & is_trail(up_m, up_l, cr)) |
             (down  & is_trail(dn_m, dn_l, cl) & is_trail(dn_m, dn_l, cr)) |
             (left  & is_trail(up_m, up_l, cl) & is_trail(dn_m, dn_l, cl)) |
             (right & is_trail(up_m, up_l, cr) & is_trail(dn_m, dn_l, cr));
  end
  // Flags update only in EVAL; game_over is sticky until reset
  always_ff @(posedge clk_65M)
    if (rst) begin
      in_shaded <= 1'b0;
      game_over <= 1'b0;
    end else if (state == EVAL) begin
      in_shaded <= shaded;
      game_over <= game_over | hazard;
    end
endmodule
